// File: rtl/inst_fetch_unit_if.sv
// Instruction fetch bus bundle: the instruction memory request/response channel
// and the decode-side hand-off, plus the fetch unit's status outputs.
interface inst_fetch_unit_if #(
  parameter int WORD_SIZE   = 16,
  parameter int TARGET_SIZE = 12
);
  // Memory side
  logic                   mem_read;
  logic [WORD_SIZE-1:0]   mem_address;
  logic [WORD_SIZE-1:0]   mem_data;
  logic                   mem_ready;
  // Decode side
  logic [WORD_SIZE-1:0]   inst_out;
  logic                   inst_valid;
  logic                   inst_ready;
  logic                   jump_valid;
  logic [TARGET_SIZE-1:0] jump_target;
  // Status
  logic [WORD_SIZE-1:0]   pc_out;
  logic [WORD_SIZE-1:0]   fetch_count;

  // The fetch unit drives requests and the held instruction.
  modport master (
    output mem_read, mem_address, inst_out, inst_valid, pc_out, fetch_count,
    input  mem_data, mem_ready, inst_ready, jump_valid, jump_target
  );

  // Memory and decode stage as seen from the other end.
  modport slave (
    input  mem_read, mem_address, inst_out, inst_valid, pc_out, fetch_count,
    output mem_data, mem_ready, inst_ready, jump_valid, jump_target
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a
// ready/valid memory handshake, holds it for decode, and applies JMP redirects
// (target = upper bits of pc+1 concatenated with the jump field).
module inst_fetch_unit #(
  parameter int                   WORD_SIZE   = 16,
  parameter int                   TARGET_SIZE = 12,
  parameter logic [WORD_SIZE-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               reset_cpu,
  input  logic               cpu_enable,
  inst_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] r_inst;
  logic [WORD_SIZE-1:0] r_count;

  logic                 w_capture;
  logic                 w_handshake;
  logic [WORD_SIZE-1:0] w_pc_inc;
  logic [WORD_SIZE-1:0] w_pc_next;

  assign w_capture   = (r_state == REQ)  && bus.mem_ready;
  assign w_handshake = (r_state == HOLD) && bus.inst_ready;
  assign w_pc_inc    = r_pc + 1'b1;
  // Jump keeps the page of the *next* PC, so a JMP in the last word of a page
  // lands in the following page.
  assign w_pc_next   = bus.jump_valid
                       ? {w_pc_inc[WORD_SIZE-1:TARGET_SIZE], bus.jump_target}
                       : w_pc_inc;

  // State register; reset abandons any outstanding request or held word.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset_cpu) r_state <= IDLE;
    else           r_state <= w_state_next;
  end

  // Next-state logic for the fetch sequence IDLE -> REQ -> HOLD.
  always_comb begin
    // NOTE: default assigned first so no path leaves the output unassigned,
    // which would otherwise infer a latch.
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (cpu_enable)     w_state_next = REQ;
      REQ:     if (bus.mem_ready)  w_state_next = HOLD;
      HOLD:    if (bus.inst_ready) w_state_next = cpu_enable ? REQ : IDLE;
      default:                     w_state_next = IDLE;
    endcase
  end

  // Datapath: capture fetched word, advance PC and consumed count on hand-off.
  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      r_pc    <= RESET_PC;
      r_inst  <= '0;
      r_count <= '0;
    end else begin
      if (w_capture) r_inst <= bus.mem_data;
      if (w_handshake) begin
        r_pc    <= w_pc_next;
        r_count <= r_count + 1'b1;
      end
    end
  end

  // All outputs come from registers or the state alone.
  assign bus.mem_read    = (r_state == REQ);
  assign bus.mem_address = r_pc;
  assign bus.inst_valid  = (r_state == HOLD);
  assign bus.inst_out    = r_inst;
  assign bus.pc_out      = r_pc;
  assign bus.fetch_count = r_count;

endmodule
